// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and constants for the load/store unit
package load_store_unit_pkg;

    localparam int unsigned LSU_DEPTH_WORDS_DEFAULT = 128;

    // Request access size as carried on reqSize.
    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_INVALID = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/ls_lane_align.sv
// rtl/ls_lane_align.sv - combinational load lane extraction and store lane merge
//
// Ports:
//   size_i      access size of the registered request
//   signed_i    sign-extend sub-word loads
//   offset_i    byte offset within the word (addr[1:0])
//   rdata_i     word read from memory
//   wdata_i     low 16 bits of the store data (sub-word stores only)
//   load_data_o right-aligned, extended load result
//   merged_o    rdata_i with the addressed lane replaced by store data
module ls_lane_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        signed_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // Little-endian lanes: byte lane = offset, halfword lane = offset[1].
        byte_v = rdata_i[{offset_i, 3'b000} +: 8];
        half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        merged_o    = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o = {{24{signed_i & byte_v[7]}}, byte_v};
                merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SIZE_HALF: begin
                load_data_o = {{16{signed_i & half_v[15]}}, half_v};
                merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit in front of a word memory
//
// Ports:
//   clock, resetN                          clock and asynchronous active-low reset
//   reqValid/reqReady/reqWrite/reqSize/
//   reqSigned/reqAddr/reqWdata              request channel
//   respValid/respReady/respData/respError  response channel
//   memAddress/memWriteData/memWrite/
//   memRead/memReadData                     word-wide data memory port
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = LSU_DEPTH_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    lsu_state_e  state_q, state_d;
    lsu_size_e   size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;

    lsu_size_e   req_size;
    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_size = lsu_size_e'(reqSize);
    assign req_bad  = (req_size == SIZE_INVALID)
                   || (req_size == SIZE_HALF && reqAddr[0])
                   || (req_size == SIZE_WORD && reqAddr[1:0] != 2'b00)
                   || ({1'b0, reqAddr} >= ADDR_LIMIT);

    ls_lane_align u_lane_align (
        .size_i      (size_q),
        .signed_i    (signed_q),
        .offset_i    (addr_q[1:0]),
        .rdata_i     (memReadData),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    // Memory-side outputs are computed for the next state so they are
    // registered and stable for the whole cycle of a memory access.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_write_d  = 1'b0;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    size_d       = req_size;
                    signed_d     = reqSigned;
                    addr_d       = reqAddr;
                    wdata_d      = reqWdata[15:0];
                    resp_data_d  = '0;
                    resp_error_d = 1'b0;
                    if (req_bad) begin
                        state_d      = ST_RESP;
                        resp_error_d = 1'b1;
                    end else if (!reqWrite) begin
                        state_d    = ST_READ;
                        mem_addr_d = {reqAddr[31:2], 2'b00};
                    end else if (req_size == SIZE_WORD) begin
                        state_d     = ST_WRITE;
                        mem_addr_d  = {reqAddr[31:2], 2'b00};
                        mem_wdata_d = reqWdata;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d    = ST_RMW_READ;
                        mem_addr_d = {reqAddr[31:2], 2'b00};
                    end
                end
            end
            ST_READ: begin
                state_d     = ST_RESP;
                resp_data_d = load_data;
            end
            ST_RMW_READ: begin
                state_d     = ST_WRITE;
                mem_addr_d  = {addr_q[31:2], 2'b00};
                mem_wdata_d = merged_word;
                mem_write_d = 1'b1;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (respReady) begin
                    state_d      = ST_IDLE;
                    resp_data_d  = '0;
                    resp_error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign reqReady     = (state_q == ST_IDLE);
    assign respValid    = (state_q == ST_RESP);
    assign respData     = resp_data_q;
    assign respError    = resp_error_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign memWrite     = mem_write_q;
    assign memRead      = (state_q == ST_READ) || (state_q == ST_RMW_READ);

endmodule
